// File: rtl/tick_sched_if.sv
// Configurator and requester signals of the tick scheduler.
// The master side offers ratios and requests; the slave side is the scheduler.
interface tick_sched_if #(
   parameter int NREQ = 4,
   parameter int DIVW = 8
);
   logic [DIVW-1:0] div_value;
   logic            div_load;
   logic            div_ready;
   logic [NREQ-1:0] req;
   logic            tick;
   logic [NREQ-1:0] grant;
   logic            idle;

   modport master (
      output div_value, div_load, req,
      input  div_ready, tick, grant, idle
   );

   modport slave (
      input  div_value, div_load, req,
      output div_ready, tick, grant, idle
   );
endinterface

// File: rtl/tick_sched.sv
// Divided-tick scheduler: a phase counter produces one tick every div cycles,
// and each tick is handed round-robin to one of NREQ requesters. The ratio can
// be changed through a ready/valid handshake; a new ratio only takes effect at
// a period boundary so the period in progress is never cut or stretched.
module tick_sched #(
   parameter int NREQ        = 4,
   parameter int DIVW        = 8,
   parameter int DEFAULT_DIV = 3
) (
   input logic        clk,
   input logic        reset,
   tick_sched_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [DIVW-1:0] cnt;
   logic [DIVW-1:0] div;
   logic [DIVW-1:0] pend;
   logic            rdy;
   logic [PW-1:0]   ptr;
   logic            tick_q;
   logic [NREQ-1:0] grant_q;
   logic            idle_q;

   logic            wrap;
   logic [NREQ-1:0] arb_gnt;
   logic [PW-1:0]   arb_idx;
   logic            arb_hit;
   logic [PW-1:0]   cand;

   // div is never zero (a zero load is stored as 1), so div-1 cannot underflow
   assign wrap = (cnt == div - DIVW'(1));

   // Round-robin pick: scan from ptr+1 upward (wrapping), first requester wins
   always_comb begin
      arb_gnt = '0;
      arb_idx = ptr;
      arb_hit = 1'b0;
      cand    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = PW'((int'(ptr) + i) % NREQ);
         if (!arb_hit && bus.req[cand]) begin
            arb_hit = 1'b1;
            arb_idx = cand;
         end
      end
      if (arb_hit) arb_gnt[arb_idx] = 1'b1;
   end

   // Phase counter, registered tick/grant/idle, and the pending-ratio handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         div     <= DIVW'(DEFAULT_DIV);
         pend    <= '0;
         rdy     <= 1'b1;
         ptr     <= PW'(NREQ - 1);
         tick_q  <= 1'b0;
         grant_q <= '0;
         idle_q  <= 1'b0;
      end else begin
         if (wrap) begin
            cnt     <= '0;
            tick_q  <= 1'b1;
            grant_q <= arb_gnt;
            idle_q  <= !arb_hit;
            if (arb_hit) ptr <= arb_idx;
            // a ratio accepted on an earlier edge becomes active for the next period
            if (!rdy) begin
               div <= pend;
               rdy <= 1'b1;
            end
         end else begin
            cnt     <= cnt + DIVW'(1);
            tick_q  <= 1'b0;
            grant_q <= '0;
            idle_q  <= 1'b0;
         end
         // accept only when nothing is pending; apply and accept are exclusive on rdy
         if (bus.div_load && rdy) begin
            pend <= (bus.div_value == '0) ? DIVW'(1) : bus.div_value;
            rdy  <= 1'b0;
         end
      end
   end

   assign bus.div_ready = rdy;
   assign bus.tick      = tick_q;
   assign bus.grant     = grant_q;
   assign bus.idle      = idle_q;
endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: cycle-by-cycle vector table plus a randomized
// property run for one-hot grants, period length and fairness.
module tb_tick_sched;
   logic clk = 1'b0;
   logic reset;

   tick_sched_if #(.NREQ(4), .DIVW(8)) bus ();

   tick_sched #(.NREQ(4), .DIVW(8), .DEFAULT_DIV(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       ld;
      logic [7:0] val;
      logic       tick;
      logic [3:0] grant;
      logic       idle;
      logic       rdy;
   } vec_t;

   vec_t tbl[$];
   int   passed = 0;
   int   total  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic addv(input logic rst, input logic [3:0] rq, input logic ld, input logic [7:0] v,
                       input logic tk, input logic [3:0] g, input logic id, input logic rd);
      vec_t e;
      e.rst = rst; e.req = rq; e.ld = ld; e.val = v;
      e.tick = tk; e.grant = g; e.idle = id; e.rdy = rd;
      tbl.push_back(e);
   endtask

   // one full period of length n with ready high: n-1 quiet cycles then a tick
   task automatic addp(input logic [3:0] rq, input int n, input logic [3:0] g);
      for (int i = 0; i < n - 1; i++) addv(1'b0, rq, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b1);
      addv(1'b0, rq, 1'b0, 8'd0, 1'b1, g, (g == 4'h0), 1'b1);
   endtask

   initial begin
      int gap;
      int wait0;
      reset         = 1'b1;
      bus.req       = '0;
      bus.div_load  = 1'b0;
      bus.div_value = '0;

      // reset, then idle ticks at 3,6,9,12
      addv(1'b1, 4'h0, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b1);
      repeat (4) addp(4'h0, 3, 4'h0);
      // all requesting: rotation starting at requester 0
      addp(4'hf, 3, 4'h1); addp(4'hf, 3, 4'h2); addp(4'hf, 3, 4'h4);
      addp(4'hf, 3, 4'h8); addp(4'hf, 3, 4'h1);
      // single requester gets every tick, then a second one joins
      addp(4'h4, 3, 4'h4); addp(4'h4, 3, 4'h4);
      addp(4'h5, 3, 4'h1); addp(4'h5, 3, 4'h4);
      // req only matters at the wrap edge
      addv(1'b0, 4'hf, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b1);
      addv(1'b0, 4'hf, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b1);
      addv(1'b0, 4'h0, 1'b0, 8'd0, 1'b1, 4'h0, 1'b1, 1'b1);
      addv(1'b0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b1);
      addv(1'b0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b1);
      addv(1'b0, 4'h2, 1'b0, 8'd0, 1'b1, 4'h2, 1'b0, 1'b1);
      // load 5 mid-period: current period stays 3, then period 5
      addv(1'b0, 4'h0, 1'b1, 8'd5, 1'b0, 4'h0, 1'b0, 1'b0);
      addv(1'b0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b0);
      addv(1'b0, 4'h0, 1'b0, 8'd0, 1'b1, 4'h0, 1'b1, 1'b1);
      addp(4'h0, 5, 4'h0); addp(4'h0, 5, 4'h0);
      // load 2 on a wrap edge: applies one period later
      repeat (4) addv(1'b0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b1);
      addv(1'b0, 4'h0, 1'b1, 8'd2, 1'b1, 4'h0, 1'b1, 1'b0);
      repeat (4) addv(1'b0, 4'h0, 1'b0, 8'd0, 1'b0, 4'h0, 1'b0, 1'b0);
      addv(1'b0, 4'h0, 1'b0, 8'd0, 1'b1, 4'h0, 1'b1, 1'b1);
      addp(4'h0, 2, 4'h0); addp(4'h0, 2, 4'h0);
      // load 0 (treated as 1); second load while busy is dropped
      addv(1'b0, 4'h0, 1'b1, 8'd0, 1'b0, 4'h0, 1'b0, 1'b0);
      addv(1'b0, 4'h0, 1'b1, 8'd7, 1'b1, 4'h0, 1'b1, 1'b1);
      addv(1'b0, 4'hf, 1'b0, 8'd0, 1'b1, 4'h4, 1'b0, 1'b1);
      addv(1'b0, 4'hf, 1'b0, 8'd0, 1'b1, 4'h8, 1'b0, 1'b1);
      addv(1'b0, 4'hf, 1'b0, 8'd0, 1'b1, 4'h1, 1'b0, 1'b1);
      addv(1'b0, 4'hf, 1'b0, 8'd0, 1'b1, 4'h2, 1'b0, 1'b1);
      addv(1'b0, 4'hf, 1'b0, 8'd0, 1'b1, 4'h4, 1'b0, 1'b1);
      // load 9 at div 1 (every edge is a wrap), applied on the next edge
      addv(1'b0, 4'hf, 1'b1, 8'd9, 1'b1, 4'h8, 1'b0, 1'b0);
      addv(1'b0, 4'hf, 1'b0, 8'd0, 1'b1, 4'h1, 1'b0, 1'b1);
      // pending load at cnt=1, then reset (with a load offered) wins
      addv(1'b0, 4'h0, 1'b1, 8'd6, 1'b0, 4'h0, 1'b0, 1'b0);
      addv(1'b1, 4'hf, 1'b1, 8'd3, 1'b0, 4'h0, 1'b0, 1'b1);
      addp(4'hf, 3, 4'h1); addp(4'hf, 3, 4'h2); addp(4'hf, 3, 4'h4);

      foreach (tbl[r]) begin
         @(negedge clk);
         reset         = tbl[r].rst;
         bus.req       = tbl[r].req;
         bus.div_load  = tbl[r].ld;
         bus.div_value = tbl[r].val;
         @(posedge clk);
         #1;
         chk($sformatf("row%0d tick", r),  32'(bus.tick),      32'(tbl[r].tick));
         chk($sformatf("row%0d grant", r), 32'(bus.grant),     32'(tbl[r].grant));
         chk($sformatf("row%0d idle", r),  32'(bus.idle),      32'(tbl[r].idle));
         chk($sformatf("row%0d ready", r), 32'(bus.div_ready), 32'(tbl[r].rdy));
      end

      // random requests with requester 0 always asking: structural properties
      gap   = 0;
      wait0 = 0;
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         reset        = 1'b0;
         bus.div_load = 1'b0;
         bus.req      = 4'(($urandom_range(0, 15)) | 1);
         @(posedge clk);
         #1;
         gap++;
         chk($sformatf("rnd%0d grant onehot", c), 32'($onehot0(bus.grant)), 32'd1);
         if (!bus.tick)
            chk($sformatf("rnd%0d grant/idle outside tick", c), 32'({bus.grant, bus.idle}), 32'd0);
         if (bus.tick) begin
            chk($sformatf("rnd%0d period", c), 32'(gap), 32'd3);
            chk($sformatf("rnd%0d grant when requested", c), 32'(bus.idle), 32'd0);
            gap = 0;
            if (bus.grant[0]) wait0 = 0;
            else wait0++;
            chk($sformatf("rnd%0d req0 wait bound", c), 32'(wait0 <= 3), 32'd1);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
